instr_encoder: RTL and testbench

- Back-end instruction emitter for the TTA core; produces the 24-bit instruction words consumed by the decode unit.
- Accepts move / literal-load requests over a valid/ready handshake and packs them into r-type or l-type words.
- Splits 24-bit literals into low/high l-type pairs as needed.
- Writes words sequentially into instruction memory through a write port with backpressure; used by the program loader and the self-test sequencer.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 112 +++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus between an instruction source and instr_encoder.
// The master drives requests and the memory stall; the slave (encoder) drives ready and the write port.
interface instr_encoder_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_kind;
  logic          req_cond;
  logic [6:0]    req_src;
  logic [6:0]    req_dest;
  logic [23:0]   req_lit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          mem_stall;

  modport slave (
    input  req_valid, req_kind, req_cond, req_src, req_dest, req_lit, mem_stall,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_kind, req_cond, req_src, req_dest, req_lit, mem_stall,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// TTA instruction emitter: packs move/literal requests into 24-bit r/l-type words; ENC_NOP_ELIDE_EN drops no-op moves.
// Latency: first mem_we one cycle after accept, one word per cycle when unstalled.
// Backpressure: mem_stall freezes the write port; req_ready is low while emitting, while full, or during restart.
module instr_encoder #(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           restart,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           full,
  output logic [AW:0]    word_count
);

  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [AW-1:0] LAST_A = '1;

  typedef enum logic [1:0] {IDLE, EMIT_LO, EMIT_HI} state_t;

  state_t      state;
  logic        rdy_q;
  logic        cond_q;
  logic [6:0]  dest_q;
  logic [11:0] hi_q;
  logic        hi_pend_q;
  logic        accept;
  logic        elide;
  logic        last;

  function automatic logic [23:0] r_word(input logic cond, input logic [6:0] dest,
                                         input logic [6:0] src);
    return {1'b0, cond, 3'b000, dest, src, 5'b00000};
  endfunction

  function automatic logic [23:0] l_word(input logic cond, input logic hl,
                                         input logic [6:0] dest, input logic [11:0] lit);
    return {1'b1, cond, hl, 2'b00, dest, lit};
  endfunction

  // Restart has priority over a same-cycle request.
  assign bus.req_ready = rdy_q & ~restart;
  assign accept        = bus.req_valid & bus.req_ready;
  assign last          = (bus.mem_addr == LAST_A);

`ifdef ENC_NOP_ELIDE_EN
  assign elide = ~bus.req_kind & ~bus.req_cond & (bus.req_src == bus.req_dest);
`else
  assign elide = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rdy_q         <= 1'b1;
      cond_q        <= 1'b0;
      dest_q        <= '0;
      hi_q          <= '0;
      hi_pend_q     <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_A;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      full          <= 1'b0;
      word_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (restart) begin
            bus.mem_addr <= BASE_A;
            word_count   <= '0;
            full         <= 1'b0;
            rdy_q        <= 1'b1;
          end else if (accept && !elide) begin
            cond_q     <= bus.req_cond;
            dest_q     <= bus.req_dest;
            hi_q       <= bus.req_lit[23:12];
            hi_pend_q  <= bus.req_kind & (|bus.req_lit[23:12]);
            bus.mem_wdata <= bus.req_kind
                           ? l_word(bus.req_cond, 1'b0, bus.req_dest, bus.req_lit[11:0])
                           : r_word(bus.req_cond, bus.req_dest, bus.req_src);
            bus.mem_we <= 1'b1;
            busy       <= 1'b1;
            rdy_q      <= 1'b0;
            state      <= EMIT_LO;
          end
        end
        EMIT_LO, EMIT_HI: begin
          if (!bus.mem_stall) begin
            word_count <= word_count + (AW+1)'(1);
            // The pointer parks on the last address once memory is full.
            if (last) full <= 1'b1;
            else      bus.mem_addr <= bus.mem_addr + AW'(1);
            if (state == EMIT_LO && hi_pend_q && !last) begin
              bus.mem_wdata <= l_word(cond_q, 1'b1, dest_q, hi_q);
              state         <= EMIT_HI;
            end else begin
              bus.mem_we <= 1'b0;
              busy       <= 1'b0;
              rdy_q      <= ~last;
              hi_pend_q  <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (AW=2, BASE=0): vector table plus stall, full and restart sequences.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          restart;
  logic          busy;
  logic          full;
  logic [AW:0]   word_count;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.AW(AW), .BASE(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .bus        (bus.slave),
    .busy       (busy),
    .full       (full),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa[$];
  logic [23:0]   wd[$];

  // A write completes on the next rising edge when we is high and stall is low.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && bus.mem_stall === 1'b0) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  typedef struct {
    logic        kind;
    logic        cond;
    logic [6:0]  src;
    logic [6:0]  dest;
    logic [23:0] lit;
    int          n;
    logic [23:0] w0;
    logic [23:0] w1;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_restart();
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic send(input string nm, input logic kind, input logic cond,
                      input logic [6:0] src, input logic [6:0] dest, input logic [23:0] lit);
    @(posedge clk); #1;
    bus.req_kind  = kind;
    bus.req_cond  = cond;
    bus.req_src   = src;
    bus.req_dest  = dest;
    bus.req_lit   = lit;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 40);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tv[0] = '{1'b0, 1'b1, 7'h15, 7'h2A, 24'h0,      1, 24'h42A2A0, 24'h0};
    tv[1] = '{1'b1, 1'b0, 7'h00, 7'h05, 24'h000ABC, 1, 24'h805ABC, 24'h0};
    tv[2] = '{1'b1, 1'b1, 7'h00, 7'h7F, 24'h123456, 2, 24'hC7F456, 24'hE7F123};
    tv[3] = '{1'b0, 1'b0, 7'h01, 7'h02, 24'h0,      1, 24'h002020, 24'h0};
    tv[4] = '{1'b1, 1'b0, 7'h00, 7'h03, 24'h001000, 2, 24'h803000, 24'hA03001};
    tv[5] = '{1'b1, 1'b1, 7'h00, 7'h00, 24'h000000, 1, 24'hC00000, 24'h0};
`ifdef ENC_NOP_ELIDE_EN
    tv[6] = '{1'b0, 1'b0, 7'h10, 7'h10, 24'h0,      0, 24'h0,      24'h0};
`else
    tv[6] = '{1'b0, 1'b0, 7'h10, 7'h10, 24'h0,      1, 24'h010200, 24'h0};
`endif
    tv[7] = '{1'b0, 1'b1, 7'h10, 7'h10, 24'h0,      1, 24'h410200, 24'h0};

    rst           = 1'b1;
    restart       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_kind  = 1'b0;
    bus.req_cond  = 1'b0;
    bus.req_src   = '0;
    bus.req_dest  = '0;
    bus.req_lit   = '0;
    bus.mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_we",    32'(bus.mem_we),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_full",  32'(full),          32'd0);
    chk("rst_count", 32'(word_count),    32'd0);

    for (int i = 0; i < 8; i++) begin
      do_restart();
      wa.delete();
      wd.delete();
      send($sformatf("v%0d", i), tv[i].kind, tv[i].cond, tv[i].src, tv[i].dest, tv[i].lit);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_nwords", i), 32'(wd.size()), 32'(tv[i].n));
      chk($sformatf("v%0d_count", i), 32'(word_count), 32'(tv[i].n));
      if (wd.size() > 0 && tv[i].n > 0) begin
        chk($sformatf("v%0d_w0", i), 32'(wd[0]), 32'(tv[i].w0));
        chk($sformatf("v%0d_a0", i), 32'(wa[0]), 32'd0);
      end
      if (wd.size() > 1 && tv[i].n > 1) begin
        chk($sformatf("v%0d_w1", i), 32'(wd[1]), 32'(tv[i].w1));
        chk($sformatf("v%0d_a1", i), 32'(wa[1]), 32'd1);
      end
    end

    // Stall for three cycles while the high word is on the port.
    do_restart();
    wa.delete();
    wd.delete();
    send("stl", 1'b1, 1'b1, 7'h00, 7'h7F, 24'h123456);
    @(negedge clk);
    chk("stl_lo_we",    32'(bus.mem_we),    32'd1);
    chk("stl_lo_wdata", 32'(bus.mem_wdata), 32'hC7F456);
    chk("stl_lo_rdy",   32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stl_hold%0d_we", c),    32'(bus.mem_we),    32'd1);
      chk($sformatf("stl_hold%0d_addr", c),  32'(bus.mem_addr),  32'd1);
      chk($sformatf("stl_hold%0d_wdata", c), 32'(bus.mem_wdata), 32'hE7F123);
      chk($sformatf("stl_hold%0d_rdy", c),   32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_stall = 1'b0;
    wait_idle("stl");
    chk("stl_nwords", 32'(wd.size()), 32'd2);
    chk("stl_count",  32'(word_count), 32'd2);
    if (wd.size() == 2) chk("stl_w1", 32'(wd[1]), 32'hE7F123);

    // Fill addresses 0..2, then a literal at the last address drops its high word.
    do_restart();
    for (int k = 0; k < 3; k++) begin
      send($sformatf("fill%0d", k), 1'b0, 1'b0, 7'h01, 7'h02, 24'h0);
      wait_idle($sformatf("fill%0d", k));
    end
    chk("fill_count", 32'(word_count), 32'd3);
    wa.delete();
    wd.delete();
    send("full", 1'b1, 1'b0, 7'h00, 7'h01, 24'hFFFFFF);
    wait_idle("full");
    chk("full_nwords", 32'(wd.size()), 32'd1);
    if (wd.size() > 0) begin
      chk("full_w0", 32'(wd[0]), 32'h801FFF);
      chk("full_a0", 32'(wa[0]), 32'd3);
    end
    chk("full_flag",  32'(full),       32'd1);
    chk("full_count", 32'(word_count), 32'd4);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("full_blk%0d_rdy", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("full_blk%0d_we", c),  32'(bus.mem_we),    32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    do_restart();
    @(negedge clk);
    chk("rs_addr",  32'(bus.mem_addr),  32'd0);
    chk("rs_full",  32'(full),          32'd0);
    chk("rs_count", 32'(word_count),    32'd0);
    chk("rs_rdy",   32'(bus.req_ready), 32'd1);

    // Restart and a request in the same cycle: restart wins.
    send("pre", 1'b0, 1'b1, 7'h15, 7'h2A, 24'h0);
    wait_idle("pre");
    chk("pre_count", 32'(word_count), 32'd1);
    @(posedge clk); #1;
    restart       = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("coll_rdy", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    restart       = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("coll_we",    32'(bus.mem_we),   32'd0);
    chk("coll_busy",  32'(busy),         32'd0);
    chk("coll_count", 32'(word_count),   32'd0);
    chk("coll_addr",  32'(bus.mem_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
